// File: rtl/avalon_arb2_pkg.sv
// Shared definitions for the two-master Avalon-MM arbiter: state encoding,
// grant encodings and the bus widths used by nano5.
package avalon_arb2_pkg;

    localparam int NANO5_WIDTHA = 12;
    localparam int NANO5_WIDTHD = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/avalon_arb2_if.sv
// One Avalon-MM link (master side drives the request). The lock signal exists
// only when ARB_LOCK_EN is defined.
interface avalon_arb2_if
    import avalon_arb2_pkg::*;
#(
    parameter int WIDTHA = NANO5_WIDTHA,
    parameter int WIDTHD = NANO5_WIDTHD
) ();

    logic [WIDTHA-1:0]   address;
    logic [WIDTHD-1:0]   writedata;
    logic [WIDTHD/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [WIDTHD-1:0]   readdata;
    logic                waitrequest;
`ifdef ARB_LOCK_EN
    logic                lock;

    modport master (
        output address, writedata, byteenable, read, write, lock,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, read, write, lock,
        output readdata, waitrequest
    );
`else
    modport master (
        output address, writedata, byteenable, read, write,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, read, write,
        output readdata, waitrequest
    );
`endif

endinterface

// File: rtl/arb_lock_cnt.sv
// Counts consecutive completed transfers made by a locked owner; saturates at
// LOCKMAX and flags when the next completion is the LOCKMAX-th one.
module arb_lock_cnt #(
    parameter int LOCKMAX = 8
) (
    input  logic clock,
    input  logic areset,
    input  logic lock,
    input  logic complete,
    input  logic clear,
    output logic at_limit
);

    localparam int CNT_W = $clog2(LOCKMAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCKMAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKMAX - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (clear || !lock) begin
            cnt <= '0;
        end else if (complete && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit = (cnt >= CNT_LAST);

endmodule

// File: rtl/avalon_arb2.sv
// Two-master round-robin Avalon-MM arbiter onto one shared slave port.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
module avalon_arb2
    import avalon_arb2_pkg::*;
#(
    parameter int WIDTHA  = NANO5_WIDTHA,
    parameter int WIDTHD  = NANO5_WIDTHD,
    parameter int LOCKMAX = 8
) (
    input  logic          clock,
    input  logic          areset,
    avalon_arb2_if.slave  m0,
    avalon_arb2_if.slave  m1,
    avalon_arb2_if.master s,
    output logic [1:0]    grant
);

    arb_state_t state, state_nxt;

    logic req0, req1;
    logic granted, sel1;
    logic own_req, oth_req, complete, hold;

    logic [WIDTHA-1:0]   sel_address;
    logic [WIDTHD-1:0]   sel_writedata;
    logic [WIDTHD/8-1:0] sel_byteenable;

    assign req0     = m0.read | m0.write;
    assign req1     = m1.read | m1.write;
    assign granted  = (state == GNT0) || (state == GNT1);
    assign sel1     = (state == GNT1);
    assign own_req  = sel1 ? req1 : req0;
    assign oth_req  = sel1 ? req0 : req1;
    assign complete = granted & own_req & ~s.waitrequest;

`ifdef ARB_LOCK_EN
    logic own_lock, lock_limit, switch_owner;

    assign own_lock     = granted & (sel1 ? m1.lock : m0.lock);
    assign switch_owner = granted & (state_nxt != state);

    arb_lock_cnt #(.LOCKMAX(LOCKMAX)) u_lock_cnt (
        .clock    (clock),
        .areset   (areset),
        .lock     (own_lock),
        .complete (complete),
        .clear    (switch_owner),
        .at_limit (lock_limit)
    );

    assign hold = own_lock & ~lock_limit;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A busy owner only hands over on a completing cycle; an idle owner
    // yields to any request from the other master.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (own_req ? (complete & oth_req & ~hold) : oth_req) begin
                    state_nxt = sel1 ? GNT0 : GNT1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_address    = sel1 ? m1.address    : m0.address;
    assign sel_writedata  = sel1 ? m1.writedata  : m0.writedata;
    assign sel_byteenable = sel1 ? m1.byteenable : m0.byteenable;

    assign s.address    = sel_address;
    assign s.writedata  = sel_writedata;
    assign s.byteenable = sel_byteenable;
    assign s.read       = granted & (sel1 ? m1.read  : m0.read);
    assign s.write      = granted & (sel1 ? m1.write : m0.write);

    assign m0.readdata    = s.readdata;
    assign m1.readdata    = s.readdata;
    assign m0.waitrequest = (state == GNT0) ? s.waitrequest : 1'b1;
    assign m1.waitrequest = (state == GNT1) ? s.waitrequest : 1'b1;

    always_comb begin
        grant = GRANT_NONE;
        case (state)
            GNT0:    grant = GRANT_M0;
            GNT1:    grant = GRANT_M1;
            default: grant = GRANT_NONE;
        endcase
    end

endmodule

// File: tb/tb_avalon_arb2.sv
// Directed self-checking bench for avalon_arb2; lock scenarios run when
// ARB_LOCK_EN is defined.
module tb_avalon_arb2;

    logic       clock = 1'b0;
    logic       areset;
    logic [1:0] grant;
    int         checks   = 0;
    int         failures = 0;

    avalon_arb2_if #(.WIDTHA(12), .WIDTHD(32)) m0_if (), m1_if (), s_if ();

    avalon_arb2 #(.WIDTHA(12), .WIDTHD(32), .LOCKMAX(3)) u_dut (
        .clock  (clock),
        .areset (areset),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if),
        .grant  (grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  exp_grant [8];
        logic [1:0]  exp_cnt   [6];

        areset = 1'b1;
        m0_if.address = '0; m0_if.writedata = '0; m0_if.byteenable = '0;
        m0_if.read = 1'b0;  m0_if.write = 1'b0;
        m1_if.address = '0; m1_if.writedata = '0; m1_if.byteenable = '0;
        m1_if.read = 1'b0;  m1_if.write = 1'b0;
`ifdef ARB_LOCK_EN
        m0_if.lock = 1'b0;
        m1_if.lock = 1'b0;
`endif
        s_if.readdata    = '0;
        s_if.waitrequest = 1'b0;

        // Reset state
        #12;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_sread", 64'(s_if.read), 64'h0);
        check("rst_swrite", 64'(s_if.write), 64'h0);
        check("rst_m0wait", 64'(m0_if.waitrequest), 64'h1);
        check("rst_m1wait", 64'(m1_if.waitrequest), 64'h1);
        cyc();
        areset = 1'b0;

        // Single m0 read from IDLE: presented one cycle later
        m0_if.address = 12'h004;
        m0_if.read    = 1'b1;
        #1;
        check("idle_grant", 64'(grant), 64'h0);
        check("idle_sread", 64'(s_if.read), 64'h0);
        check("idle_m0wait", 64'(m0_if.waitrequest), 64'h1);
        cyc();
        check("rd_grant", 64'(grant), 64'h1);
        check("rd_sread", 64'(s_if.read), 64'h1);
        check("rd_addr", 64'(s_if.address), 64'h004);
        check("rd_m0wait", 64'(m0_if.waitrequest), 64'h0);
        check("rd_m1wait", 64'(m1_if.waitrequest), 64'h1);
        s_if.readdata = 32'hDEAD_BEEF;
        #1;
        check("rd_m0data", 64'(m0_if.readdata), 64'hDEAD_BEEF);
        check("rd_m1data", 64'(m1_if.readdata), 64'hDEAD_BEEF);
        m0_if.read = 1'b0;
        cyc();
        check("park_grant", 64'(grant), 64'h1);
        check("park_sread", 64'(s_if.read), 64'h0);

        // Continuous writes from both masters alternate every cycle
        m0_if.address = 12'h010; m0_if.writedata = 32'h1111_0000; m0_if.byteenable = 4'hF;
        m1_if.address = 12'h020; m1_if.writedata = 32'h2222_0000; m1_if.byteenable = 4'h3;
        m0_if.write = 1'b1;
        m1_if.write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", 64'(grant), (i % 2 == 1) ? 64'h2 : 64'h1);
            check("rr_swrite", 64'(s_if.write), 64'h1);
            check("rr_wdata", 64'(s_if.writedata), (i % 2 == 1) ? 64'h2222_0000 : 64'h1111_0000);
            check("rr_be", 64'(s_if.byteenable), (i % 2 == 1) ? 64'h3 : 64'hF);
            check("rr_m0wait", 64'(m0_if.waitrequest), (i % 2 == 1) ? 64'h1 : 64'h0);
            check("rr_m1wait", 64'(m1_if.waitrequest), (i % 2 == 1) ? 64'h0 : 64'h1);
            cyc();
        end
        m0_if.write = 1'b0;
        m1_if.write = 1'b0;
        cyc();

        // Stalled m0 read holds the grant while m1 waits
        s_if.waitrequest = 1'b1;
        m0_if.address = 12'h030; m0_if.read = 1'b1;
        m1_if.address = 12'h040; m1_if.writedata = 32'h3333_4444; m1_if.write = 1'b1;
        #1;
        check("stall_grant0", 64'(grant), 64'h1);
        check("stall_addr0", 64'(s_if.address), 64'h030);
        check("stall_m0wait", 64'(m0_if.waitrequest), 64'h1);
        check("stall_m1wait", 64'(m1_if.waitrequest), 64'h1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_grant", 64'(grant), 64'h1);
            check("stall_addr", 64'(s_if.address), 64'h030);
            check("stall_sread", 64'(s_if.read), 64'h1);
            check("stall_swrite", 64'(s_if.write), 64'h0);
        end
        s_if.waitrequest = 1'b0;
        #1;
        check("stall_done_m0wait", 64'(m0_if.waitrequest), 64'h0);
        check("stall_done_grant", 64'(grant), 64'h1);
        cyc();
        check("sw_grant", 64'(grant), 64'h2);
        check("sw_swrite", 64'(s_if.write), 64'h1);
        check("sw_addr", 64'(s_if.address), 64'h040);
        check("sw_m1wait", 64'(m1_if.waitrequest), 64'h0);
        m0_if.read = 1'b0;

        // Asynchronous reset during a stalled m1 write
        s_if.waitrequest = 1'b1;
        m0_if.address = 12'h050;
        m0_if.read    = 1'b1;
        #1;
        check("m1stall_grant", 64'(grant), 64'h2);
        check("m1stall_m1wait", 64'(m1_if.waitrequest), 64'h1);
        cyc();
        check("m1stall_hold", 64'(grant), 64'h2);
        #2;
        areset = 1'b1;
        #1;
        check("arst_grant", 64'(grant), 64'h0);
        check("arst_swrite", 64'(s_if.write), 64'h0);
        check("arst_sread", 64'(s_if.read), 64'h0);
        check("arst_m0wait", 64'(m0_if.waitrequest), 64'h1);
        check("arst_m1wait", 64'(m1_if.waitrequest), 64'h1);
        cyc();
        check("arst_edge_grant", 64'(grant), 64'h0);
        areset = 1'b0;
        s_if.waitrequest = 1'b0;
        #1;
        check("post_rst_idle", 64'(grant), 64'h0);
        cyc();
        check("post_rst_grant", 64'(grant), 64'h1);
        check("post_rst_sread", 64'(s_if.read), 64'h1);
        check("post_rst_addr", 64'(s_if.address), 64'h050);
        cyc();
        check("post_rst_next", 64'(grant), 64'h2);
        m0_if.read  = 1'b0;
        m1_if.write = 1'b0;
        cyc();

`ifdef ARB_LOCK_EN
        // m0 locked, both requesting: three m0 transfers then one m1
        areset = 1'b1;
        #1;
        areset = 1'b0;
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        m0_if.address = 12'h060; m0_if.write = 1'b1; m0_if.lock = 1'b1;
        m1_if.address = 12'h070; m1_if.write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("lock0_grant", 64'(grant), 64'(exp_grant[i]));
        end
        m0_if.write = 1'b0; m0_if.lock = 1'b0;
        m1_if.write = 1'b0;

        // m1 locked with m0 idle: grant retained, counter saturates
        areset = 1'b1;
        #1;
        areset = 1'b0;
        exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        m1_if.write = 1'b1; m1_if.lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("lock1_grant", 64'(grant), 64'h2);
            check("lock1_cnt", 64'(u_dut.u_lock_cnt.cnt), 64'(exp_cnt[i]));
        end
        m0_if.write = 1'b1;
        #1;
        check("lock1_sat_hold", 64'(grant), 64'h2);
        cyc();
        check("lock1_sat_switch", 64'(grant), 64'h1);
        check("lock1_cnt_clr", 64'(u_dut.u_lock_cnt.cnt), 64'h0);
        m0_if.write = 1'b0;
        m1_if.write = 1'b0; m1_if.lock = 1'b0;
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_arb2.md
AVALON_ARB2 -- requirements
Module: avalon_arb2

Interface
REQ-001 SHALL have parameter WIDTHA, default 12, meaning word address width.
REQ-002 SHALL have parameter WIDTHD, default 32, meaning data width; byteenable width is WIDTHD/8.
REQ-003 SHALL have parameter LOCKMAX, default 8, meaning the maximum number of consecutive completed transfers a locked master may hold the grant.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 mN_address/mN_writedata/mN_byteenable/mN_read/mN_write  in  WIDTHA/WIDTHD/WIDTHD/8/1/1  master N request (N=0,1); master 0 is the nano5 CPU.
REQ-007 mN_readdata  out  WIDTHD  read return to master N.
REQ-008 mN_waitrequest  out  1  stall to master N.
REQ-009 mN_lock  in  1  master N requests to keep the grant (present only with ARB_LOCK_EN).
REQ-010 s_address/s_writedata/s_byteenable/s_read/s_write  out  WIDTHA/WIDTHD/WIDTHD/8/1/1  shared slave port.
REQ-011 s_readdata  in  WIDTHD; s_waitrequest  in  1; grant  out  2  one-hot current owner (bit N = master N).

Function
REQ-012 SHALL implement states IDLE, GNT0, GNT1; reqN = mN_read | mN_write.
REQ-013 IDLE: s_read = s_write = 0, both mN_waitrequest = 1, grant = 2'b00; on the next edge go to GNT0 if req0, else GNT1 if req1, else stay.
REQ-014 GNTn: s_* request signals SHALL be combinationally driven from master n; mn_waitrequest = s_waitrequest; the other master's waitrequest = 1; grant bit n = 1.
REQ-015 mN_readdata SHALL equal s_readdata for both masters at all times; validity is qualified by the owning master's handshake.
REQ-016 A transfer completes in GNTn on a cycle with reqn & ~s_waitrequest.
REQ-017 On completion: if the other master requests and no lock holds, switch to the other GNT state on that edge; otherwise stay in GNTn (parked).
REQ-018 In GNTn with reqn = 0: switch to the other GNT state if it requests, else stay parked.
REQ-019 SHALL never change owner while reqn = 1 and s_waitrequest = 1 (no mid-transfer switch); slave request signals SHALL stay stable through the stall.
REQ-020 Arbitration latency: a request to an idle or parked-other arbiter is presented on s_* no later than one cycle after assertion.
REQ-021 Round-robin SHALL guarantee that with both masters requesting continuously, ownership alternates every completed transfer (lock excepted).
REQ-022 Simultaneous first requests from IDLE: master 0 wins.

Reset
REQ-023 areset SHALL force IDLE immediately, with no clock edge required: s_read = s_write = 0, grant = 0, both waitrequest = 1, lock counter = 0.
REQ-024 A transfer in progress at reset SHALL be abandoned; after release the arbiter re-arbitrates from IDLE.
REQ-025 s_address, s_writedata and s_byteenable are don't-care while s_read = s_write = 0.

Configuration
REQ-026 Macro ARB_LOCK_EN: when defined, mN_lock ports exist; with mn_lock = 1 at completion the grant is retained regardless of the other request, and a counter of consecutive locked completions forces a switch after the LOCKMAX-th completion when the other master requests; the counter clears on switch or when lock = 0.
REQ-027 Counter width SHALL be $clog2(LOCKMAX+1) bits and SHALL saturate, never wrap.
REQ-028 When ARB_LOCK_EN is undefined: lock ports are absent, no counter exists, and behaviour is pure round-robin per REQ-017.

Structure
REQ-029 A shared package SHALL hold the arbiter state enum, the grant encoding constants and the default WIDTHA/WIDTHD values shared with nano5.
REQ-030 Lock counting SHALL be one sub-module, arb_lock_cnt, instantiated only under ARB_LOCK_EN; all other logic stays in avalon_arb2.

Verification
REQ-031 Reset, then req0 read of address 0x004 with s_waitrequest = 0 -> s_read = 1, s_address = 0x004 one cycle later; m0_waitrequest drops that cycle; grant = 01.
REQ-032 Both masters issue continuous writes with s_waitrequest = 0 -> s_write owners alternate 0,1,0,1; each master completes once per 2 cycles.
REQ-033 Master 0 read stalled by s_waitrequest = 1 for 5 cycles while m1_write = 1 -> grant stays 01 and s_* stays stable; the switch to 1 occurs on the edge of completion.
REQ-034 Assert areset during a stalled master 1 write -> s_write = 0 and grant = 00 asynchronously; after release, the pending m0 request is served first.
REQ-035 With ARB_LOCK_EN and LOCKMAX = 3, m0_lock = 1 and both masters requesting -> 3 consecutive m0 transfers, then 1 m1 transfer, then m0 again.
REQ-036 With ARB_LOCK_EN, m1_lock = 1 and m0 idle -> m1 retains the grant indefinitely; the counter saturates at 3 without wrapping.
